// File: rtl/tube_word_unpacker.sv
// Reader-side tube-word unpacker: drains the 16-bit FIFO and rebuilds 256-bit event frames.
// Optional idle timeout inside a partial frame: define UNPACK_TIMEOUT_EN.
module tube_word_unpacker #(
  parameter int WORDS_PER_FRAME = 32,
  parameter int TIME_W = 8,
  parameter logic [TIME_W-1:0] NO_HIT = 8'hFF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk100,
  input  logic                              rst_n,
  input  logic                              fifo_empty,
  input  logic                              fifo_valid,
  input  logic [15:0]                       fifo_dout,
  output logic                              rd_en,
  output logic [WORDS_PER_FRAME*TIME_W-1:0] frame_data,
  output logic                              frame_valid,
  input  logic                              frame_ready,
  output logic [5:0]                        hit_count,
  output logic                              seq_err,
  output logic [7:0]                        err_count,
  output logic [15:0]                       frame_count
);

  localparam int IDX_W = $clog2(WORDS_PER_FRAME) + 1;
  localparam int SLOT_W = IDX_W - 1;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    RESYNC,
    COLLECT,
    HOLD
  } state_t;

  state_t state, state_d;

  logic [WORDS_PER_FRAME-1:0][TIME_W-1:0] slots;
  logic [IDX_W-1:0]  word_idx;
  logic [SLOT_W-1:0] slot;
  logic [7:0]        exp_hdr;
  logic [5:0]        hits;
  logic inflight;
  logic accept;
  logic hdr_ok;
  logic store;
  logic err_now;
  logic handshake;
  logic timeout;

  // slots[31] holds tube 0 so it lands in the top byte of frame_data
  assign frame_data = slots;
  assign slot = LAST - word_idx[SLOT_W-1:0];
  assign accept = fifo_valid && inflight;
  assign hdr_ok = (fifo_dout[15:8] == exp_hdr);

  always_comb begin
    exp_hdr = 8'h00;
    unique case (word_idx[4:3])
      2'd0: exp_hdr[7:4] = 4'hC;
      2'd1: exp_hdr[7:4] = 4'hD;
      2'd2: exp_hdr[7:4] = 4'h2;
      2'd3: exp_hdr[7:4] = 4'h3;
    endcase
    exp_hdr[2:0] = word_idx[2:0];
  end

  always_comb begin
    hits = '0;
    for (int k = 0; k < WORDS_PER_FRAME; k++) begin
      if (slots[k] != NO_HIT) hits = hits + 6'd1;
    end
  end

`ifdef UNPACK_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMR_W-1:0] idle_cnt;
  logic idle;

  assign idle = (state == COLLECT) && (word_idx != '0) && !fifo_valid;
  assign timeout = idle && (idle_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk100) begin
    if (!rst_n || !idle || timeout) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    rd_en = 1'b0;
    store = 1'b0;
    err_now = 1'b0;
    handshake = 1'b0;
    unique case (state)
      RESYNC: begin
        rd_en = rst_n && !fifo_empty;
        if (accept && hdr_ok) begin
          store = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // never request more words than the frame still needs
        rd_en = rst_n && !fifo_empty &&
          ((word_idx + IDX_W'(inflight)) < IDX_W'(WORDS_PER_FRAME));
        if (accept) begin
          if (hdr_ok) begin
            store = 1'b1;
            if (word_idx == IDX_W'(WORDS_PER_FRAME - 1)) state_d = HOLD;
          end else begin
            err_now = 1'b1;
            state_d = RESYNC;
          end
        end else if (timeout) begin
          err_now = 1'b1;
          state_d = RESYNC;
        end
      end
      HOLD: begin
        if (frame_valid && frame_ready) begin
          handshake = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = RESYNC;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state <= RESYNC;
      slots <= {WORDS_PER_FRAME{NO_HIT}};
      word_idx <= '0;
      inflight <= 1'b0;
      frame_valid <= 1'b0;
      hit_count <= '0;
      seq_err <= 1'b0;
      err_count <= '0;
      frame_count <= '0;
    end else begin
      state <= state_d;
      inflight <= rd_en;
      seq_err <= err_now;
      if (err_now) begin
        slots <= {WORDS_PER_FRAME{NO_HIT}};
        word_idx <= '0;
        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
      end
      if (store) begin
        slots[slot] <= fifo_dout[TIME_W-1:0];
        word_idx <= word_idx + 1'b1;
      end
      if (state == HOLD && !frame_valid) begin
        frame_valid <= 1'b1;
        hit_count <= hits;
      end
      if (handshake) begin
        frame_valid <= 1'b0;
        frame_count <= frame_count + 1'b1;
        slots <= {WORDS_PER_FRAME{NO_HIT}};
        word_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tube_word_unpacker.sv
// Directed bench for tube_word_unpacker: FIFO model, frame table, error/hold/timeout sequences.
// Timeout sequence follows UNPACK_TIMEOUT_EN the same way the design does.
module tb_tube_word_unpacker;

  logic         clk100 = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty;
  logic         fifo_valid = 1'b0;
  logic [15:0]  fifo_dout = '0;
  logic         rd_en;
  logic [255:0] frame_data;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  logic [5:0]   hit_count;
  logic         seq_err;
  logic [7:0]   err_count;
  logic [15:0]  frame_count;

  always #5 clk100 = ~clk100;

  tube_word_unpacker dut (
    .clk100(clk100),
    .rst_n(rst_n),
    .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid),
    .fifo_dout(fifo_dout),
    .rd_en(rd_en),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .hit_count(hit_count),
    .seq_err(seq_err),
    .err_count(err_count),
    .frame_count(frame_count)
  );

  logic [15:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk100) begin
    fifo_valid <= 1'b0;
    if (rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 4096];
      rd_ptr <= rd_ptr + 1;
      fifo_valid <= 1'b1;
    end
  end

  int seq_cnt = 0;
  int frames_seen = 0;
  logic [255:0] cap_data = '0;
  logic [5:0]   cap_hits = '0;

  always @(negedge clk100) begin
    if (seq_err) seq_cnt++;
    if (frame_valid && frame_ready) begin
      frames_seen++;
      cap_data = frame_data;
      cap_hits = hit_count;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_word(input int n, input logic [7:0] t);
    logic [4:0] idx;
    logic [3:0] tag;
    idx = 5'(n);
    case (idx[4:3])
      2'd0: tag = 4'hC;
      2'd1: tag = 4'hD;
      2'd2: tag = 4'h2;
      default: tag = 4'h3;
    endcase
    return {tag, 1'b0, idx[2:0], t};
  endfunction

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 4096] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [7:0] byte_at(input logic [255:0] d, input int k);
    return d[255-8*k -: 8];
  endfunction

  task automatic wait_frames(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk100);
      n++;
    end
    chk(name, 256'(frames_seen >= target), 256'(1));
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [31:0] mask;
    int          sp_slot;
    logic [7:0]  sp_val;
    int          pa;
    logic [7:0]  ea;
    int          pb;
    logic [7:0]  eb;
    int          hits;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] time_of(input vec_t v, input int k);
    if (k == v.sp_slot) return v.sp_val;
    if (v.mask[k]) return 8'hFF;
    return v.base + 8'(k);
  endfunction

  initial begin
    int exp_frames;
    int seq_base;
    logic [255:0] snap;
    logic stable;
    int n;

    vecs[0] = '{8'h00, 32'h0000_0000, 99, 8'h00, 0, 8'h00, 31, 8'h1F, 32};
    vecs[1] = '{8'h00, 32'hFFFF_FFFF, 19, 8'h42, 19, 8'h42, 0, 8'hFF, 1};
    vecs[2] = '{8'h10, 32'h0000_00FF, 99, 8'h00, 0, 8'hFF, 8, 8'h18, 24};
    vecs[3] = '{8'h20, 32'h8000_0001, 99, 8'h00, 1, 8'h21, 30, 8'h3E, 30};
    vecs[4] = '{8'h80, 32'hAAAA_AAAA, 99, 8'h00, 2, 8'h82, 3, 8'hFF, 16};
    vecs[5] = '{8'h00, 32'h0000_0000, 5, 8'hFF, 5, 8'hFF, 6, 8'h06, 31};
    exp_frames = 0;

    // reset with junk already waiting in the FIFO
    rst_n = 1'b0;
    frame_ready = 1'b1;
    @(posedge clk100);
    #1;
    push(mk_word(8, 8'h11));
    push(mk_word(1, 8'h22));
    repeat (2) @(posedge clk100);
    @(negedge clk100);
    chk("rst_rd_en", 256'(rd_en), 256'(0));
    chk("rst_frame_valid", 256'(frame_valid), 256'(0));
    chk("rst_err_count", 256'(err_count), 256'(0));
    chk("rst_frame_count", 256'(frame_count), 256'(0));
    chk("rst_frame_data", frame_data, {256{1'b1}});
    chk("rst_hit_count", 256'(hit_count), 256'(0));
    chk("rst_seq_err", 256'(seq_err), 256'(0));
    @(posedge clk100);
    #1;
    rst_n = 1'b1;

    // table of full frames, consumer always ready
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 32; k++) push(mk_word(k, time_of(vecs[i], k)));
      exp_frames++;
      wait_frames($sformatf("vec%0d_frame", i), exp_frames, 300);
      chk($sformatf("vec%0d_hits", i), 256'(cap_hits), 256'(vecs[i].hits));
      chk($sformatf("vec%0d_byte_a", i), 256'(byte_at(cap_data, vecs[i].pa)), 256'(vecs[i].ea));
      chk($sformatf("vec%0d_byte_b", i), 256'(byte_at(cap_data, vecs[i].pb)), 256'(vecs[i].eb));
      @(negedge clk100);
      chk($sformatf("vec%0d_frame_count", i), 256'(frame_count), 256'(exp_frames));
      chk($sformatf("vec%0d_no_seq_err", i), 256'(seq_cnt), 256'(0));
    end

    // word 5 carries tube 6: partial frame dropped, next frame accepted
    seq_base = seq_cnt;
    @(posedge clk100);
    #1;
    for (int k = 0; k < 5; k++) push(mk_word(k, 8'h01));
    push(mk_word(6, 8'h01));
    for (int k = 0; k < 32; k++) push(mk_word(k, 8'h50 + 8'(k)));
    exp_frames++;
    wait_frames("err_recover_frame", exp_frames, 300);
    chk("err_seq_pulses", 256'(seq_cnt - seq_base), 256'(1));
    chk("err_count_1", 256'(err_count), 256'(1));
    chk("err_recover_hits", 256'(cap_hits), 256'(32));
    chk("err_recover_b0", 256'(byte_at(cap_data, 0)), 256'(8'h50));
    chk("err_recover_b5", 256'(byte_at(cap_data, 5)), 256'(8'h55));
    @(negedge clk100);
    chk("err_frame_count", 256'(frame_count), 256'(exp_frames));

    // consumer stalls for 10 cycles with the next frame queued
    @(posedge clk100);
    #1;
    frame_ready = 1'b0;
    for (int k = 0; k < 32; k++) push(mk_word(k, 8'h60 + 8'(k)));
    n = 0;
    while (!frame_valid && n < 300) begin
      @(negedge clk100);
      n++;
    end
    chk("hold_valid", 256'(frame_valid), 256'(1));
    snap = frame_data;
    chk("hold_b0", 256'(byte_at(snap, 0)), 256'(8'h60));
    @(posedge clk100);
    #1;
    for (int k = 0; k < 32; k++) push(mk_word(k, 8'h70 + 8'(k)));
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk100);
      if (rd_en !== 1'b0 || frame_data !== snap || frame_valid !== 1'b1) stable = 1'b0;
    end
    chk("hold_stable", 256'(stable), 256'(1));
    chk("hold_frame_count", 256'(frame_count), 256'(exp_frames));
    @(posedge clk100);
    #1;
    frame_ready = 1'b1;
    exp_frames += 2;
    wait_frames("hold_release", exp_frames, 300);
    chk("hold_next_b0", 256'(byte_at(cap_data, 0)), 256'(8'h70));
    @(negedge clk100);
    chk("hold_frame_count_after", 256'(frame_count), 256'(exp_frames));

    // ten words then a long silence
    seq_base = seq_cnt;
    @(posedge clk100);
    #1;
    for (int k = 0; k < 10; k++) push(mk_word(k, 8'h05));
    repeat (1100) @(negedge clk100);
`ifdef UNPACK_TIMEOUT_EN
    chk("tmo_seq_pulses", 256'(seq_cnt - seq_base), 256'(1));
    chk("tmo_err_count", 256'(err_count), 256'(2));
    @(posedge clk100);
    #1;
    for (int k = 0; k < 32; k++) push(mk_word(k, 8'h30 + 8'(k)));
    exp_frames++;
    wait_frames("tmo_recover_frame", exp_frames, 300);
    chk("tmo_recover_b0", 256'(byte_at(cap_data, 0)), 256'(8'h30));
`else
    chk("wait_no_seq", 256'(seq_cnt - seq_base), 256'(0));
    chk("wait_err_count", 256'(err_count), 256'(1));
    chk("wait_no_frame", 256'(frames_seen), 256'(exp_frames));
    @(posedge clk100);
    #1;
    for (int k = 10; k < 32; k++) push(mk_word(k, 8'h05));
    exp_frames++;
    wait_frames("wait_complete_frame", exp_frames, 300);
    chk("wait_b0", 256'(byte_at(cap_data, 0)), 256'(8'h05));
`endif
    chk("final_hits", 256'(cap_hits), 256'(32));
    @(negedge clk100);
    chk("final_frame_count", 256'(frame_count), 256'(exp_frames));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
